// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} tx_state_t;

    localparam int MAX_DATA_WIDTH = 9;
    localparam int STOP_CNT_W     = 1;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Loadable down-counter timing one serial bit; bit_end_o marks the last cycle of the bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic bit_end_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(CLKS_PER_BIT - 1);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a synchronous FIFO (1-cycle read latency)
// and sends start, LSB-first data, optional parity and 1-2 stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    tx_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [STOP_CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
    logic                    parity_q, parity_d;
    logic                    tx_q, tx_d;
    logic                    busy_q;
    logic                    bit_end;
    logic                    last_stop;
    logic [MAX_DATA_WIDTH-1:0] word_ext;

    assign word_ext  = MAX_DATA_WIDTH'(fifo_data_i);
    assign last_stop = (state_q == STOP) && bit_end &&
                       (stop_cnt_q == STOP_CNT_W'(STOP_BITS - 1));

    // The pop decision is taken in the same cycle the frame ends, so frames run back-to-back.
    assign fifo_rd_en_o = (state_q == IDLE || last_stop) && !fifo_empty_i && tx_enable_i && !reset;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    ((state_q == FETCH) || (state_q != IDLE && bit_end)),
        .en_i      (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    // tx_d carries the line level of the state being entered, so tx_q is aligned with state_q.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_rd_en_o) state_d = FETCH;
            end
            FETCH: begin
                shift_d  = fifo_data_i;
                parity_d = calc_parity(word_ext, PARITY_ODD != 0);
                state_d  = START;
                tx_d     = 1'b0;
            end
            START: if (bit_end) begin
                state_d   = DATA;
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = '0;
            end
            DATA: if (bit_end) begin
                if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                    stop_cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            PARITY: if (bit_end) begin
                state_d    = STOP;
                tx_d       = 1'b1;
                stop_cnt_d = '0;
            end
            STOP: if (bit_end) begin
                tx_d = 1'b1;
                if (last_stop) begin
                    state_d = fifo_rd_en_o ? FETCH : IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + STOP_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations share one stimulus stream, each with
// its own FIFO model and a frame-level reference model checked every cycle.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] fempty, rd, txw, busy, fd;
    logic [7:0] fdata [3];

    logic [7:0] mem [3][64];
    int         wp [3] = '{0, 0, 0};
    int         rp [3] = '{0, 0, 0};

    int         ph [3] = '{0, 0, 0};
    int         tt [3] = '{0, 0, 0};
    int         mrp [3] = '{0, 0, 0};
    logic [7:0] cw [3];

    logic       inf [3] = '{0, 0, 0};
    logic       garm [3] = '{0, 0, 0};
    int         cyc [3], gap [3], last_gap [3], last_len [3], rdc [3];
    logic [15:0] cap [3], last_cap [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Configs: 0 = no parity/1 stop, 1 = even parity/1 stop, 2 = odd parity/2 stops
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(rst), .tx_enable_i(en), .fifo_empty_i(fempty[0]), .fifo_rd_en_o(rd[0]),
        .fifo_data_i(fdata[0]), .tx_o(txw[0]), .busy_o(busy[0]), .frame_done_o(fd[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(rst), .tx_enable_i(en), .fifo_empty_i(fempty[1]), .fifo_rd_en_o(rd[1]),
        .fifo_data_i(fdata[1]), .tx_o(txw[1]), .busy_o(busy[1]), .frame_done_o(fd[1]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(rst), .tx_enable_i(en), .fifo_empty_i(fempty[2]), .fifo_rd_en_o(rd[2]),
        .fifo_data_i(fdata[2]), .tx_o(txw[2]), .busy_o(busy[2]), .frame_done_o(fd[2]));

    always_comb begin
        for (int g = 0; g < 3; g++) fempty[g] = (wp[g] == rp[g]);
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rd[g] && wp[g] != rp[g]) begin
                fdata[g] <= mem[g][rp[g]];
                rp[g]    <= rp[g] + 1;
            end
        end
    end

    function automatic int pe_of(int g); return (g != 0) ? 1 : 0; endfunction
    function automatic int po_of(int g); return (g == 2) ? 1 : 0; endfunction
    function automatic int sb_of(int g); return (g == 2) ? 2 : 1; endfunction
    function automatic int flen(int g);  return (1 + 8 + pe_of(g) + sb_of(g)) * CPB; endfunction

    // Line level of serial bit b of a frame carrying w.
    function automatic logic exp_bit(int g, logic [7:0] w, int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (pe_of(g) != 0 && b == 9) return (^w) ^ (po_of(g) != 0);
        return 1'b1;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        for (int g = 0; g < 3; g++) begin
            logic etx, ebusy, efd, erd, mempty;
            int   L;
            L = flen(g);
            mempty = (mrp[g] == wp[g]);
            etx = 1'b1; ebusy = 1'b0; efd = 1'b0; erd = 1'b0;
            if (!rst) begin
                case (ph[g])
                    0: erd = en && !mempty;
                    1: ebusy = 1'b1;
                    default: begin
                        ebusy = 1'b1;
                        etx   = exp_bit(g, cw[g], tt[g] / CPB);
                        efd   = (tt[g] == L - 1);
                        erd   = efd && en && !mempty;
                    end
                endcase
            end
            chk($sformatf("tx[%0d]", g), int'(txw[g]), int'(etx));
            chk($sformatf("busy[%0d]", g), int'(busy[g]), int'(ebusy));
            chk($sformatf("frame_done[%0d]", g), int'(fd[g]), int'(efd));
            chk($sformatf("fifo_rd_en[%0d]", g), int'(rd[g]), int'(erd));

            // Observations of the DUT used for the hand-computed checks
            if (rst) begin
                inf[g] = 1'b0; garm[g] = 1'b0;
            end else begin
                if (rd[g]) rdc[g]++;
                if (!inf[g] && busy[g] && !txw[g]) begin
                    inf[g] = 1'b1; cyc[g] = 0; cap[g] = '0;
                    if (garm[g]) begin last_gap[g] = gap[g]; garm[g] = 1'b0; end
                end else if (garm[g] && txw[g]) begin
                    gap[g]++;
                end
                if (inf[g]) begin
                    cyc[g]++;
                    if ((cyc[g] - 1) % CPB == 1) cap[g][(cyc[g] - 1) / CPB] = txw[g];
                    if (fd[g]) begin
                        last_len[g] = cyc[g]; last_cap[g] = cap[g];
                        inf[g] = 1'b0; garm[g] = 1'b1; gap[g] = 0;
                    end
                end
            end

            if (rst) begin
                ph[g] = 0;
            end else begin
                case (ph[g])
                    0: if (erd) begin ph[g] = 1; cw[g] = mem[g][mrp[g]]; mrp[g]++; end
                    1: begin ph[g] = 2; tt[g] = 0; end
                    default: begin
                        if (tt[g] < L - 1) tt[g]++;
                        else if (erd) begin ph[g] = 1; cw[g] = mem[g][mrp[g]]; mrp[g]++; end
                        else ph[g] = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [7:0] w);
        for (int g = 0; g < 3; g++) begin
            mem[g][wp[g]] = w;
            wp[g]++;
        end
    endtask

    function automatic logic all_idle();
        for (int g = 0; g < 3; g++)
            if (ph[g] != 0 || mrp[g] != wp[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(int maxc, string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < maxc);
        if (!all_idle()) chk({name, " timeout"}, n, -1);
        repeat (2) step();
    endtask

    task automatic clr_rdc();
        for (int g = 0; g < 3; g++) rdc[g] = 0;
    endtask

    initial begin
        clr_rdc();
        repeat (3) step();
        rst = 1'b0;
        en  = 1'b1;

        // Empty FIFO: nothing should move
        repeat (100) step();
        for (int g = 0; g < 3; g++) chk($sformatf("empty rd count[%0d]", g), rdc[g], 0);

        // Single 0xA5 frame in every configuration
        push(8'hA5);
        wait_idle(200, "single");
        chk("A5 bits cfg0", int'(last_cap[0][9:0]), int'(10'b1101001010));
        chk("A5 len cfg0", last_len[0], 40);
        chk("A5 len cfg1", last_len[1], 44);
        chk("A5 len cfg2", last_len[2], 48);
        chk("A5 even parity", int'(last_cap[1][9]), 0);
        chk("A5 odd parity", int'(last_cap[2][9]), 1);
        for (int g = 0; g < 3; g++) chk($sformatf("A5 rd count[%0d]", g), rdc[g], 1);

        // Back-to-back frames
        clr_rdc();
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_idle(400, "b2b");
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("b2b rd count[%0d]", g), rdc[g], 3);
            chk($sformatf("b2b gap[%0d]", g), last_gap[g], 1);
        end
        chk("b2b last word cfg0", int'(last_cap[0][8:1]), 'h3C);

        // tx_enable dropped mid-frame with two words queued
        clr_rdc();
        push(8'h11); push(8'h22);
        repeat (20) step();
        en = 1'b0;
        repeat (120) step();
        for (int g = 0; g < 3; g++) chk($sformatf("hold rd count[%0d]", g), rdc[g], 1);
        chk("hold first word cfg1", int'(last_cap[1][8:1]), 'h11);
        en = 1'b1;
        wait_idle(200, "resume");
        for (int g = 0; g < 3; g++) chk($sformatf("resume rd count[%0d]", g), rdc[g], 2);
        chk("resume word cfg0", int'(last_cap[0][8:1]), 'h22);

        // Reset in the middle of data bit 3 of 0x5A; 0x77 must follow intact
        push(8'h5A); push(8'h77);
        begin
            int n = 0;
            while (!(ph[0] == 2 && tt[0] == 4 * CPB + 1) && n < 200) begin step(); n++; end
            if (n >= 200) chk("reach data bit 3 timeout", n, -1);
        end
        rst = 1'b1;
        repeat (3) step();
        clr_rdc();
        rst = 1'b0;
        wait_idle(200, "after reset");
        for (int g = 0; g < 3; g++) chk($sformatf("post-reset rd count[%0d]", g), rdc[g], 1);
        chk("post-reset word cfg0", int'(last_cap[0][8:1]), 'h77);
        chk("post-reset word cfg2", int'(last_cap[2][8:1]), 'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
